lcd_text_ctrl: RTL
==================

# lcd_text_ctrl

Parametrised character-LCD controller for HD44780-compatible 8-bit-bus panels, and the next generation of the team's LCD front end. It runs the panel power-up/initialisation sequence on its own, then accepts whole-row write requests (one row of COLS characters with a row index) and full-screen clear requests. It generates all bus timing with internal counters and reports completion with a Ready/Done handshake. It sits between the SIM-data formatting logic and the panel pins and replaces the fixed 2-row, 20-column controller.

## Interface
Parameters:
- ROWS, 2: display rows. Legal values are 1 to 4.
- COLS, 20: characters per row. Legal values are 1 to 40.
- E_PULSE, 12: number of CLK cycles LCD_E is held high per byte.
- CMD_WAIT, 2000: CLK cycles waited after each non-clear byte, counted after LCD_E falls.
- CLR_WAIT, 82000: CLK cycles waited after a clear command (0x01).
- PWR_WAIT, 750000: CLK cycles waited after reset before the first init byte.

Ports:
- CLK, input, 1: system clock. All registers update on the rising edge.
- Reset_n, input, 1: asynchronous, active-low reset.
- Limpiar, input, 1: clear-display request. Sampled only while Ready=1.
- Escribir, input, 1: row-write request. Sampled only while Ready=1.
- Fila, input, 2: target row index.
- Dato_LCD, input, 8*COLS: row text. Character 0 (leftmost) is Dato_LCD[8*COLS-1 -: 8].
- Ready, output, 1: controller idle and able to accept a request.
- Done, output, 1: one-cycle pulse when an accepted request finishes.
- Error, output, 1: one-cycle pulse when a request is rejected.
- LCD_RS, output, 1: 0 = command, 1 = data.
- LCD_E, output, 1: panel enable strobe.
- LCD_DB, output, 8: panel data bus.

## Operation
- Byte transfer (shared by all states). Drive LCD_RS and LCD_DB, then:
  - 1 setup cycle with LCD_E=0;
  - E_PULSE cycles with LCD_E=1;
  - a wait of CMD_WAIT cycles, or CLR_WAIT if the byte is command 0x01, with LCD_E=0.
  - LCD_RS and LCD_DB stay stable for the whole transfer.
- State machine: PWR → INIT → IDLE → {CLEAR | ADDR → CHARS} → FIN → IDLE.
  - PWR: wait PWR_WAIT cycles.
  - INIT: send commands 0x38, 0x0C, 0x06, 0x01 in that order.
  - IDLE: Ready=1.
    - If Limpiar=1 → CLEAR. Limpiar has priority over Escribir when both are high.
    - Else if Escribir=1 and Fila<ROWS → ADDR. Dato_LCD and Fila are latched on the accept edge.
    - Else if Escribir=1 and Fila≥ROWS → pulse Error, stay in IDLE, issue no bus activity and no Done.
  - CLEAR: send command 0x01, then → FIN.
  - ADDR: send command 0x80 | base(row), then → CHARS.
    - base(0)=0x00, base(1)=0x40, base(2)=COLS, base(3)=0x40+COLS.
  - CHARS: send COLS data bytes (RS=1) from the latched buffer, leftmost character first. A character index counter counts 0..COLS-1. → FIN after the last character.
  - FIN: Done=1 for exactly one cycle, then → IDLE.
- Ready is 1 only in IDLE. It falls on the edge after a request is accepted.
- Input changes after acceptance have no effect, because the buffer is latched.
- Requests asserted while Ready=0 are ignored, not queued.

## Timing
- Reset values: LCD_E=0, LCD_RS=0, LCD_DB=0x00, Ready=0, Done=0, Error=0. The FSM resets to PWR and all counters clear.
- Reset_n asserted mid-transfer drops LCD_E immediately (asynchronously). After release, the full PWR+INIT sequence reruns.
- Let T_B = 1 + E_PULSE + CMD_WAIT and T_C = 1 + E_PULSE + CLR_WAIT.
- Init latency: Ready rises PWR_WAIT + 3·T_B + T_C cycles after Reset_n is released.
- Row write: from the accept edge to Done high takes (1+COLS)·T_B cycles. Ready returns one cycle after the Done pulse.
- Clear: from the accept edge to Done high takes T_C cycles.
- Error is asserted in the cycle after the rejected request is sampled. Ready stays 1.
- Counter widths are sized from the largest of PWR_WAIT and CLR_WAIT. Counters saturate at zero and never wrap.

## Test plan
Use sim parameters ROWS=2, COLS=16, E_PULSE=2, CMD_WAIT=4, CLR_WAIT=8, PWR_WAIT=20, so T_B=7 and T_C=11.
- Reset release → bus shows 0x38, 0x0C, 0x06, 0x01 with RS=0, each with a 2-cycle E pulse. Ready rises exactly 52 cycles after release.
- Escribir with Fila=1 and text "SIM OK" padded with spaces → bus shows 0x C0, then 16 RS=1 bytes starting 0x53, 0x49, 0x4D. Done pulses once, 119 cycles after accept.
- Limpiar and Escribir asserted in the same cycle → only 0x01 is sent. Done comes 11 cycles later and no row bytes follow.
- Escribir with Fila=3 (≥ROWS) → one-cycle Error pulse, no LCD_E activity, Ready stays 1, no Done.
- Escribir pulsed again while Ready=0 during a row write → ignored. Exactly one Done occurs and the bus matches the first latched text.
- Reset_n pulled low during the 5th character's E pulse → LCD_E=0 and all outputs at reset values at once. Ready returns 52 cycles after release.

Source files
------------

// File: rtl/lcd_text_if.sv
// Request/handshake bundle between the text formatter and the LCD controller.
// The formatter drives requests and row text; the controller answers with Ready/Done/Error.
interface lcd_text_if #(
  parameter int COLS = 20
);
  logic                Limpiar;
  logic                Escribir;
  logic [1:0]          Fila;
  logic [8*COLS-1:0]   Dato_LCD;
  logic                Ready;
  logic                Done;
  logic                Error;

  modport master (output Limpiar, Escribir, Fila, Dato_LCD, input Ready, Done, Error);
  modport slave  (input Limpiar, Escribir, Fila, Dato_LCD, output Ready, Done, Error);
endinterface

// File: rtl/lcd_text_ctrl.sv
// HD44780 8-bit character LCD controller: power-up/init sequence, whole-row writes and
// full-screen clears, with all bus timing generated from internal counters.
module lcd_text_ctrl #(
  parameter int ROWS     = 2,
  parameter int COLS     = 20,
  parameter int E_PULSE  = 12,
  parameter int CMD_WAIT = 2000,
  parameter int CLR_WAIT = 82000,
  parameter int PWR_WAIT = 750000
) (
  input  logic         CLK,
  input  logic         Reset_n,
  lcd_text_if.slave    req,
  output logic         LCD_RS,
  output logic         LCD_E,
  output logic [7:0]   LCD_DB
);
  localparam int MAXW = (PWR_WAIT > CLR_WAIT) ? PWR_WAIT : CLR_WAIT;
  localparam int CW   = $clog2(MAXW + 1);
  localparam int IW   = $clog2(COLS + 4);

  localparam logic [CW-1:0] PWR_LAST = CW'(PWR_WAIT - 1);
  localparam logic [CW-1:0] E_LAST   = CW'(E_PULSE - 1);
  localparam logic [CW-1:0] CMD_LAST = CW'(CMD_WAIT - 1);
  localparam logic [CW-1:0] CLR_LAST = CW'(CLR_WAIT - 1);
  localparam logic [IW-1:0] CHR_LAST = IW'(COLS - 1);
  localparam logic [IW-1:0] INI_LAST = IW'(3);
  localparam logic [2:0]    ROWS_L   = 3'(ROWS);

  localparam logic [2:0] S_PWR   = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_IDLE  = 3'd2;
  localparam logic [2:0] S_CLEAR = 3'd3;
  localparam logic [2:0] S_ADDR  = 3'd4;
  localparam logic [2:0] S_CHARS = 3'd5;
  localparam logic [2:0] S_FIN   = 3'd6;

  localparam logic [1:0] PH_SETUP = 2'd0;
  localparam logic [1:0] PH_HIGH  = 2'd1;
  localparam logic [1:0] PH_WAIT  = 2'd2;

  logic [2:0]        state;
  logic [1:0]        ph;
  logic [CW-1:0]     cnt;
  logic [IW-1:0]     idx;
  logic              err_q;
  logic [8*COLS-1:0] line_q;

  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    case (i)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h06;
      default: return 8'h01;
    endcase
  endfunction

  // Set-DDRAM-address command for the first cell of a row (4-row panels interleave rows 2/3).
  function automatic logic [7:0] row_cmd(input logic [1:0] r);
    case (r)
      2'd0:    return 8'h80;
      2'd1:    return 8'hC0;
      2'd2:    return 8'h80 | 8'(COLS);
      default: return 8'h80 | (8'h40 + 8'(COLS));
    endcase
  endfunction

  logic byte_state, is_clr, wait_end, row_ok, take_row, next_char;

  always_comb begin
    byte_state = (state == S_INIT) || (state == S_CLEAR) ||
                 (state == S_ADDR) || (state == S_CHARS);
    is_clr     = !LCD_RS && (LCD_DB == 8'h01);
    wait_end   = byte_state && (ph == PH_WAIT) &&
                 (cnt == (is_clr ? CLR_LAST : CMD_LAST));
    row_ok     = {1'b0, req.Fila} < ROWS_L;
    take_row   = (state == S_IDLE) && !req.Limpiar && req.Escribir && row_ok;
    next_char  = wait_end && ((state == S_ADDR) || ((state == S_CHARS) && (idx != CHR_LAST)));
  end

  assign req.Ready = (state == S_IDLE);
  assign req.Done  = (state == S_FIN);
  assign req.Error = err_q;

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state  <= S_PWR;
      ph     <= PH_SETUP;
      cnt    <= '0;
      idx    <= '0;
      err_q  <= 1'b0;
      LCD_E  <= 1'b0;
      LCD_RS <= 1'b0;
      LCD_DB <= 8'h00;
    end else begin
      err_q <= 1'b0;
      case (state)
        S_PWR: begin
          if (cnt == PWR_LAST) begin
            cnt    <= '0;
            state  <= S_INIT;
            ph     <= PH_SETUP;
            idx    <= '0;
            LCD_RS <= 1'b0;
            LCD_DB <= init_cmd(2'd0);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_IDLE: begin
          if (req.Limpiar) begin
            state  <= S_CLEAR;
            ph     <= PH_SETUP;
            LCD_RS <= 1'b0;
            LCD_DB <= 8'h01;
          end else if (req.Escribir && row_ok) begin
            state  <= S_ADDR;
            ph     <= PH_SETUP;
            LCD_RS <= 1'b0;
            LCD_DB <= row_cmd(req.Fila);
          end else if (req.Escribir) begin
            err_q <= 1'b1;
          end
        end
        S_FIN: state <= S_IDLE;
        S_INIT, S_CLEAR, S_ADDR, S_CHARS: begin
          // Byte transfer: one setup cycle, E_PULSE cycles of E high, then the settle wait.
          case (ph)
            PH_SETUP: begin
              ph    <= PH_HIGH;
              LCD_E <= 1'b1;
              cnt   <= '0;
            end
            PH_HIGH: begin
              if (cnt == E_LAST) begin
                ph    <= PH_WAIT;
                LCD_E <= 1'b0;
                cnt   <= '0;
              end else begin
                cnt <= cnt + CW'(1);
              end
            end
            default: begin
              if (!wait_end) begin
                cnt <= cnt + CW'(1);
              end else begin
                cnt <= '0;
                ph  <= PH_SETUP;
                case (state)
                  S_INIT: begin
                    if (idx == INI_LAST) begin
                      state <= S_IDLE;
                    end else begin
                      idx    <= idx + IW'(1);
                      LCD_DB <= init_cmd(idx[1:0] + 2'd1);
                    end
                  end
                  S_CLEAR: state <= S_FIN;
                  S_ADDR: begin
                    state  <= S_CHARS;
                    idx    <= '0;
                    LCD_RS <= 1'b1;
                    LCD_DB <= line_q[8*COLS-1 -: 8];
                  end
                  default: begin
                    if (idx == CHR_LAST) begin
                      state <= S_FIN;
                    end else begin
                      idx    <= idx + IW'(1);
                      LCD_DB <= line_q[8*COLS-1 -: 8];
                    end
                  end
                endcase
              end
            end
          endcase
        end
        default: state <= S_PWR;
      endcase
    end
  end

  // Row text is latched on accept and shifted left so the next character is always on top.
  always_ff @(posedge CLK) begin
    if (take_row) begin
      line_q <= req.Dato_LCD;
    end else if (next_char) begin
      line_q <= line_q << 8;
    end
  end
endmodule
